// File: rtl/fcc_pkg.sv
// fcc_pkg: shared flow-control constants (port indices N,S,E,W,L = 0..4), NUM_PORTS and the per-port bit-vector type
package fcc_pkg;
  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;
  localparam int NUM_PORTS = 5;
  typedef logic [NUM_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/credit_ret_port.sv
// credit_ret_port: one port's owed-credit counter saturating at BUF_DEPTH; ports clk, rst, deq, rdy -> credit pulse, empty_nxt (counter zero next), ovf (dropped credit, only with CREDIT_RETURN_OVF_ERR_EN)
module credit_ret_port #(
  parameter int BUF_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic deq,
  input  logic rdy,
  output logic credit,
  output logic empty_nxt
`ifdef CREDIT_RETURN_OVF_ERR_EN
  ,
  output logic ovf
`endif
);
  localparam int W = $clog2(BUF_DEPTH + 1);
  localparam logic [W:0] MAX = (W+1)'(BUF_DEPTH);
  logic [W-1:0] pend, pend_nxt;
  logic [W:0] avail;
  logic send, drop;
  always_comb begin
    avail = {1'b0, pend} + {{W{1'b0}}, deq};
    send = rdy && (|avail);
    drop = !send && (avail > MAX);
    pend_nxt = send ? W'(avail - 1'b1) : drop ? W'(MAX) : W'(avail);
    empty_nxt = pend_nxt == '0;
  end
`ifdef CREDIT_RETURN_OVF_ERR_EN
  assign ovf = drop;
`endif
  always_ff @(posedge clk) begin
    pend <= rst ? '0 : pend_nxt;
    credit <= !rst && send;
  end
endmodule

// File: rtl/credit_return_gen.sv
// credit_return_gen: per-port credit-return pulse generator; ports clk, rst, deq_i, ret_rdy_i -> credit_o, idle_o, plus sticky ovf_err_o when CREDIT_RETURN_OVF_ERR_EN is defined
module credit_return_gen
  import fcc_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  port_vec_t deq_i,
  input  port_vec_t ret_rdy_i,
  output port_vec_t credit_o,
  output logic      idle_o
`ifdef CREDIT_RETURN_OVF_ERR_EN
  ,
  output logic      ovf_err_o
`endif
);
  port_vec_t empty_nxt;
`ifdef CREDIT_RETURN_OVF_ERR_EN
  port_vec_t ovf;
`endif
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    credit_ret_port #(.BUF_DEPTH(BUF_DEPTH)) u_port (
      .clk(clk),
      .rst(rst),
      .deq(deq_i[i]),
      .rdy(ret_rdy_i[i]),
      .credit(credit_o[i]),
      .empty_nxt(empty_nxt[i])
`ifdef CREDIT_RETURN_OVF_ERR_EN
      ,
      .ovf(ovf[i])
`endif
    );
  end
  always_ff @(posedge clk) begin
    idle_o <= rst || (&empty_nxt);
  end
`ifdef CREDIT_RETURN_OVF_ERR_EN
  always_ff @(posedge clk) begin
    ovf_err_o <= !rst && (ovf_err_o || (|ovf));
  end
  a_no_ovf: assert property (@(posedge clk) disable iff (rst) ovf == '0);
`endif
endmodule
